wc_to_sc_pipe: RTL and testbench

//   Pipelined, back-pressurable world-to-screen coordinate converter for the billiard renderer.

---
 rtl/wc_to_sc_pipe.sv | 125 ++++++++++++
 tb/tb_wc_to_sc_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wc_to_sc_pipe.sv
// wc_to_sc_pipe: two-stage, back-pressurable world-to-screen converter.
// S1 registers the res_y-scaled products; S2 (the output register) floors,
// clamps to the raster and flags clipped axes. A saturating counter tallies
// clipped output transfers.
//
// Handshake: a beat moves on a port when its valid and ready are both high in
// the same cycle. A source holding valid without ready keeps its payload
// stable. Both stages move together on advance = !out_valid | out_ready, and
// in_ready = advance. This makes out_ready -> in_ready a combinational path.
module wc_to_sc_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 30,
  parameter int SC_W      = 11,
  parameter int ID_W      = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [ID_W-1:0]  in_id,
  input  logic [SC_W-1:0]  res_x,
  input  logic [SC_W-1:0]  res_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SC_W-1:0]  out_x,
  output logic [SC_W-1:0]  out_y,
  output logic [ID_W-1:0]  out_id,
  output logic [1:0]       out_clip,
  input  logic             clr_count,
  output logic [CNT_W-1:0] clip_count
);

  localparam int PW = WIDTH + SC_W + 1;

  logic                 advance;
  logic                 s1_valid;
  logic signed [PW-1:0] s1_px;
  logic signed [PW-1:0] s1_py;
  logic [ID_W-1:0]      s1_id;
  logic [SC_W-1:0]      s1_res_x;
  logic [SC_W-1:0]      s1_res_y;

  logic signed [PW-1:0] in_x_ext;
  logic signed [PW-1:0] in_y_ext;
  logic signed [PW-1:0] scale_ext;
  logic signed [PW-1:0] px_c;
  logic signed [PW-1:0] py_c;
  logic [SC_W:0]        x_res;
  logic [SC_W:0]        y_res;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Sign-extend the coordinates and zero-extend res_y.
  // The products are then full width and cannot overflow.
  assign in_x_ext  = PW'($signed(in_x));
  assign in_y_ext  = PW'($signed(in_y));
  assign scale_ext = $signed(PW'({1'b0, res_y}));
  assign px_c      = in_x_ext * scale_ext;
  assign py_c      = in_y_ext * scale_ext;

  // Floor one scaled axis and clamp it to 0..res-1.
  // Returns {clipped, value}. The full-width quotient is compared before
  // narrowing, so far out-of-range values never wrap into the raster.
  function automatic logic [SC_W:0] clamp_axis(input logic signed [PW-1:0] p,
                                                input logic [SC_W-1:0]      res);
    logic signed [PW-1:0] q;
    logic signed [PW-1:0] lim;
    q   = p >>> FRAC_BITS;
    lim = (res == '0) ? '0 : PW'(res) - PW'(1);
    if (q < 0)
      return {1'b1, {SC_W{1'b0}}};
    else if (q > lim)
      return {1'b1, lim[SC_W-1:0]};
    else
      return {1'b0, q[SC_W-1:0]};
  endfunction

  // S2 combinational floor/clamp of the S1 products.
  always_comb begin
    x_res = clamp_axis(s1_px, s1_res_x);
    y_res = clamp_axis(s1_py, s1_res_y);
  end

  // Pipeline registers: both stages advance together or hold together.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_px     <= '0;
      s1_py     <= '0;
      s1_id     <= '0;
      s1_res_x  <= '0;
      s1_res_y  <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_id    <= '0;
      out_clip  <= 2'b00;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_px     <= px_c;
      s1_py     <= py_c;
      s1_id     <= in_id;
      s1_res_x  <= res_x;
      s1_res_y  <= res_y;
      out_valid <= s1_valid;
      out_x     <= x_res[SC_W-1:0];
      out_y     <= y_res[SC_W-1:0];
      out_id    <= s1_id;
      out_clip  <= {y_res[SC_W], x_res[SC_W]};
    end
  end

  // Saturating clip-event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clr_count)
      clip_count <= '0;
    else if (out_valid && out_ready && (|out_clip) && (clip_count != '1))
      clip_count <= clip_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_wc_to_sc_pipe.sv
// Testbench for wc_to_sc_pipe.
// Directed and random beats are checked against an arithmetic reference
// model through an expected-output queue.
module tb_wc_to_sc_pipe;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 30;
  localparam int SC_W      = 11;
  localparam int ID_W      = 4;
  localparam int CNT_W     = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [ID_W-1:0]  in_id;
  logic [SC_W-1:0]  res_x;
  logic [SC_W-1:0]  res_y;
  logic             out_valid;
  logic             out_ready;
  logic [SC_W-1:0]  out_x;
  logic [SC_W-1:0]  out_y;
  logic [ID_W-1:0]  out_id;
  logic [1:0]       out_clip;
  logic             clr_count;
  logic [CNT_W-1:0] clip_count;

  wc_to_sc_pipe #(
    .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .SC_W(SC_W), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_id(in_id),
    .res_x(res_x), .res_y(res_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_id(out_id), .out_clip(out_clip),
    .clr_count(clr_count), .clip_count(clip_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Expected word layout: {id[27:24], x[23:13], y[12:2], clip[1:0]}
  logic [27:0] exp_q[$];
  int          tests;
  int          fails;
  int          model_cnt;
  bit          rand_ready;
  bit          held;
  logic [27:0] held_word;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint floor_div(input longint p);
    longint d;
    longint q;
    d = longint'(1) << FRAC_BITS;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [SC_W:0] axis(input longint q, input logic [SC_W-1:0] res);
    longint lim;
    longint o;
    lim = (res == 0) ? 0 : longint'(res) - 1;
    if (q < 0) o = 0;
    else if (q > lim) o = lim;
    else o = q;
    return {(q != o), o[SC_W-1:0]};
  endfunction

  function automatic logic [27:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] id, input logic [10:0] rx,
                                        input logic [10:0] ry);
    longint px;
    longint py;
    logic [SC_W:0] ax;
    logic [SC_W:0] ay;
    px = longint'($signed(x)) * longint'(ry);
    py = longint'($signed(y)) * longint'(ry);
    ax = axis(floor_div(px), rx);
    ay = axis(floor_div(py), ry);
    return {id, ax[SC_W-1:0], ay[SC_W-1:0], ay[SC_W], ax[SC_W]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] id,
                      input logic [10:0] rx, input logic [10:0] ry,
                      input bit use_k, input logic [27:0] kexp, output int waited);
    bit acc;
    acc      = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_id    = id;
    res_x    = rx;
    res_y    = ry;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        acc = 1'b1;
        exp_q.push_back(use_k ? kexp : model(x, y, id, rx, ry));
      end else begin
        waited++;
      end
      step();
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic pulse_clr;
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  task automatic check_count(input string name, input longint exp);
    @(negedge clk);
    check(name, clip_count, exp);
    step();
  endtask

  // Random back-pressure, used only when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [27:0] w;
    logic [27:0] e;
    held = 1'b0;
    model_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
        model_cnt = 0;
      end else begin
        w = {out_id, out_x, out_y, out_clip};
        check("clip_count", clip_count, model_cnt);
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", w, held_word);
        end
        if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", w, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_word", w, e);
            if (e[1:0] != 2'b00 && model_cnt < 65535) model_cnt++;
          end
        end
        if (clr_count) model_cnt = 0;
        held      = out_valid && !out_ready;
        held_word = w;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int seen;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    in_id      = '0;
    res_x      = 11'd1280;
    res_y      = 11'd800;
    out_ready  = 1'b1;
    clr_count  = 1'b0;
    rand_ready = 1'b0;
    tests      = 0;
    fails      = 0;

    repeat (3) step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_id", out_id, 0);
    check("rst_out_clip", out_clip, 0);
    check("rst_clip_count", clip_count, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    step();

    // 1.6 / 1.0 at 1280x800, including the two-cycle latency.
    send(32'h6666_6666, 32'h4000_0000, 4'd1, 11'd1280, 11'd800, 1'b1,
         {4'd1, 11'd1279, 11'd799, 2'b10}, w);
    @(negedge clk);
    check("latency_1cyc_valid", out_valid, 0);
    @(negedge clk);
    check("latency_2cyc_valid", out_valid, 1);
    step();
    drain();
    pulse_clr();

    // -0.5 / 0.5: x clamps to 0, and the counter goes to 1.
    send(32'hE000_0000, 32'h2000_0000, 4'd2, 11'd1280, 11'd800, 1'b1,
         {4'd2, 11'd0, 11'd400, 2'b01}, w);
    drain();
    check_count("count_after_neg", 1);

    // Back-to-back stream: in_ready must never drop.
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(0, 32'h7000_0000) - 32'h2000_0000, $urandom_range(0, 32'h4000_0000),
           4'(i), 11'd1280, 11'd800, 1'b0, '0, w);
      check("stream_no_wait", w, 0);
    end
    drain();

    // Same stream with a 5-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom_range(0, 32'h7000_0000) - 32'h2000_0000, $urandom_range(0, 32'h4000_0000),
               4'(i), 11'd1280, 11'd800, 1'b0, '0, w);
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Random coordinates, resolutions and back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(($urandom_range(0, 3) == 0) ? $urandom() :
             $urandom_range(0, 32'h7000_0000) - 32'h2000_0000,
           ($urandom_range(0, 3) == 0) ? $urandom() :
             $urandom_range(0, 32'h7000_0000) - 32'h2000_0000,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
           ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
           1'b0, '0, w);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    // res_x = 0: x clamps to 0 and is flagged as clipped.
    pulse_clr();
    send(32'h4000_0000, 32'h1000_0000, 4'd3, 11'd0, 11'd800, 1'b1,
         {4'd3, 11'd0, 11'd200, 2'b01}, w);
    drain();
    check_count("count_res0", 1);

    // Saturation: 65535 clipped beats, one more, then clear.
    pulse_clr();
    for (int i = 0; i < 65535; i++)
      send(32'h4000_0000, 32'h0, 4'(i), 11'd0, 11'd800, 1'b0, '0, w);
    drain();
    check_count("count_full", 16'hFFFF);
    send(32'h4000_0000, 32'h0, 4'd9, 11'd0, 11'd800, 1'b0, '0, w);
    drain();
    check_count("count_saturated", 16'hFFFF);
    pulse_clr();
    check_count("count_cleared", 0);

    // Reset with two samples in flight.
    send(32'hE000_0000, 32'h0, 4'd5, 11'd1280, 11'd800, 1'b0, '0, w);
    drain();
    check_count("count_pre_reset", 1);
    out_ready = 1'b0;
    send(32'h1000_0000, 32'h1000_0000, 4'd6, 11'd1280, 11'd800, 1'b0, '0, w);
    send(32'h2000_0000, 32'h2000_0000, 4'd7, 11'd1280, 11'd800, 1'b0, '0, w);
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_count", clip_count, 0);
    check("post_reset_in_ready", in_ready, 1);
    step();
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      step();
    end
    check("flushed_never_emitted", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
